// File: rtl/shift_add_mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared definitions for the iterative shift-and-add multiplier:
//             default operand width, counter width and FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult_ctrl_if
//  Purpose  : Start/done handshake and operand/result bus of the multiplier.
//  Signals  : start, multiplicand, multiplier  (requester -> multiplier)
//             ready, busy, done, product       (multiplier -> requester)
//  Modports : master = requester side, slave = multiplier side
//  Revision : 1.0  initial release
// ============================================================================
interface shift_add_mult_ctrl_if
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, done, product
    );

endinterface : shift_add_mult_ctrl_if
`default_nettype wire

// File: rtl/shift_add_mult_ctrl_add_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mult_add_stage
//  Purpose  : Combinational conditional adder, sum = a + (en ? b : 0), with
//             carry-in tied to zero. The carry-out is recovered from the MSBs
//             of both addends and the sum, so only a WIDTH-bit adder is needed.
//  Ports    : a, b (in, WIDTH)  addends
//             en   (in, 1)      gates b
//             sum  (out, WIDTH) WIDTH-bit sum
//             cout (out, 1)     carry out of the MSB
//  Revision : 1.0  initial release
// ============================================================================
module mult_add_stage
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             en,
    output logic      [WIDTH-1:0] sum,
    output logic                  cout
);

    logic [WIDTH-1:0] w_b;

    assign w_b = en ? b : '0;
    assign sum = a + w_b;

    // Carry out: both MSBs set, or exactly one set and the sum MSB cleared
    // (the carry into the MSB must then have been 1).
    assign cout = (a[WIDTH-1] & w_b[WIDTH-1]) |
                  ((a[WIDTH-1] ^ w_b[WIDTH-1]) & ~sum[WIDTH-1]);

endmodule : mult_add_stage
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult_ctrl
//  Purpose  : Iterative unsigned multiplier sequencer (MULTU path). One
//             shared adder is reused over WIDTH cycles (shift-and-add).
//  Ports    : clk   (in)  rising-edge clock
//             reset (in)  asynchronous active-high reset
//             bus   (slave modport of shift_add_mult_ctrl_if):
//               start/multiplicand/multiplier in; ready/busy/done/product out
//  Timing   : start accepted at edge E0, done high in the cycle after E_WIDTH,
//             one operation every WIDTH+2 cycles with start held high.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              reset,
    shift_add_mult_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(WIDTH - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic [WIDTH-1:0]    r_m;        // multiplicand
    logic [WIDTH-1:0]    r_q;        // multiplier, shifted out LSB first
    logic [WIDTH-1:0]    r_h;        // running high half of the product
    logic [2*WIDTH-1:0]  r_product;

    logic                w_ready;
    logic                w_busy;
    logic                w_done;
    logic [WIDTH-1:0]    w_sum;
    logic                w_cout;
    logic [WIDTH-1:0]    w_h_next;
    logic [WIDTH-1:0]    w_q_next;

    mult_add_stage #(
        .WIDTH (WIDTH)
    ) u_add_stage (
        .a    (r_h),
        .b    (r_m),
        .en   (r_q[0]),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // {H,Q} <= {cout, sum, Q[W-1:1]}: the carry lands directly in the H MSB,
    // so no separate carry register has to survive between iterations.
    assign w_h_next = {w_cout, w_sum[WIDTH-1:1]};
    assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

    // Next state and state-decoded outputs (no input-to-output path).
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (r_count == c_last_count) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_h       <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_m     <= bus.multiplicand;
                        r_q     <= bus.multiplier;
                        r_h     <= '0;
                        r_count <= '0;
                    end
                end
                ST_RUN: begin
                    r_h     <= w_h_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + 1'b1;
                    // Product is published from this cycle's adder result so
                    // it is already valid while done is high.
                    if (r_count == c_last_count) begin
                        r_product <= {w_h_next, w_q_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready   = w_ready;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.product = r_product;

endmodule : shift_add_mult_ctrl
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult_ctrl
//  Purpose  : Directed self-checking bench for shift_add_mult_ctrl (WIDTH=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_add_mult_ctrl;

    localparam int c_width = 32;
    localparam int c_bound = 200;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;

    shift_add_mult_ctrl_if #(.WIDTH(c_width)) u_if ();

    shift_add_mult_ctrl #(
        .WIDTH (c_width),
        .CNT_W (6)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) until done is seen #1 after a rising edge; returns cycle.
    task automatic wait_done(input string tag, output int t);
        int n;
        n = 0;
        while (u_if.done !== 1'b1 && n < c_bound) begin
            @(posedge clk); #1;
            n++;
        end
        t = cyc;
        if (n >= c_bound) check_eq({tag, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (u_if.busy !== 1'b1 && n < c_bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= c_bound) check_eq({tag, "_busy_timeout"}, 64'd0, 64'd1);
    endtask

    // One complete operation with latency, busy-length and hold checks.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int lat;
        int busy_cnt;
        @(negedge clk);
        u_if.multiplicand = a;
        u_if.multiplier   = b;
        u_if.start        = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        lat      = 1;
        busy_cnt = (u_if.busy === 1'b1) ? 1 : 0;
        while (u_if.done !== 1'b1 && lat < c_bound) begin
            @(posedge clk); #1;
            lat++;
            if (u_if.busy === 1'b1) busy_cnt++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd33);
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        check_eq({tag, "_product"}, u_if.product, exp);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, 64'(u_if.done), 64'd0);
        check_eq({tag, "_ready_after"}, 64'(u_if.ready), 64'd1);
        check_eq({tag, "_product_held"}, u_if.product, exp);
    endtask

    initial begin
        int  t0;
        int  t1;
        int  t2;
        logic saw_done;

        n_tests = 0;
        n_fail  = 0;
        reset              = 1'b1;
        u_if.start         = 1'b0;
        u_if.multiplicand  = '0;
        u_if.multiplier    = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready",   64'(u_if.ready), 64'd1);
        check_eq("rst_busy",    64'(u_if.busy),  64'd0);
        check_eq("rst_done",    64'(u_if.done),  64'd0);
        check_eq("rst_product", u_if.product,    64'd0);

        // 1..3: basic products, carry-out path, zero and single-bit shift
        do_op("t1_3x5",   32'd3,          32'd5,          64'h0000_0000_0000_000F);
        do_op("t2_max",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
        do_op("t3_zero",  32'h0,          32'h1234_5678,  64'h0);
        do_op("t3_msb",   32'h8000_0000,  32'h2,          64'h0000_0001_0000_0000);

        // 4: start pulsed during RUN with other operands is ignored
        @(negedge clk);
        u_if.multiplicand = 32'd6;
        u_if.multiplier   = 32'd7;
        u_if.start        = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        t0 = cyc;
        repeat (5) @(posedge clk);
        #1;
        u_if.multiplicand = 32'd99;
        u_if.multiplier   = 32'd99;
        u_if.start        = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        wait_done("t4", t1);
        check_eq("t4_latency", 64'(t1 - t0 + 1), 64'd33);
        check_eq("t4_product", u_if.product, 64'd42);
        @(posedge clk); #1;
        check_eq("t4_no_restart", 64'(u_if.ready), 64'd1);

        // 5: asynchronous reset mid-RUN aborts without a done pulse
        @(negedge clk);
        u_if.multiplicand = 32'd1234;
        u_if.multiplier   = 32'd5678;
        u_if.start        = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_ready",   64'(u_if.ready), 64'd1);
        check_eq("t5_rst_busy",    64'(u_if.busy),  64'd0);
        check_eq("t5_rst_product", u_if.product,    64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (u_if.done === 1'b1) saw_done = 1'b1;
        end
        check_eq("t5_no_done", 64'(saw_done), 64'd0);
        do_op("t5_after", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        // 6: start held high for three back-to-back operations
        @(negedge clk);
        u_if.multiplicand = 32'd7;
        u_if.multiplier   = 32'd9;
        u_if.start        = 1'b1;
        wait_busy("t6a");
        u_if.multiplicand = 32'd2;
        u_if.multiplier   = 32'd2;
        wait_done("t6a", t0);
        check_eq("t6a_product", u_if.product, 64'd63);
        wait_busy("t6b");
        u_if.multiplicand = 32'd10;
        u_if.multiplier   = 32'd10;
        wait_done("t6b", t1);
        check_eq("t6b_product", u_if.product, 64'd4);
        check_eq("t6b_period", 64'(t1 - t0), 64'd34);
        wait_busy("t6c");
        u_if.start = 1'b0;
        wait_done("t6c", t2);
        check_eq("t6c_product", u_if.product, 64'd100);
        check_eq("t6c_period", 64'(t2 - t1), 64'd34);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_add_mult_ctrl
`default_nettype wire
